axi_lite_clint_slave: RTL and testbench

- AXI-Lite responder (slave) for the CPU's bus arbiter output, decoding a small CLINT-style timer window: 64-bit mtime, 64-bit mtimecmp, control register.
- Sits beside the data/instruction SRAM slave behind the arbiter.
- Provides a machine-timer interrupt level to the core.
- Independent read and write channel FSMs with a configurable read latency.

---
 rtl/axi_lite_clint_slave.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_axi_lite_clint_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_clint_slave.sv
// rtl/axi_lite_clint_slave.sv - AXI-Lite responder for a CLINT-style machine timer window
module axi_lite_clint_slave #(
  parameter logic [31:0] BASE   = 32'ha0000048,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        timer_irq
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [29:0] BASE_W      = BASE[31:2];
  localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [15:0] DIV_MAX     = 16'(DIV - 1);

  // word index of each register inside the window
  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic       {W_IDLE, W_RESP}         wr_state_e;

  // timer state
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        ctrl_en_q, ctrl_en_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] shadow_q, shadow_d;
  logic        irq_q, irq_d;
  logic        tick;

  // read channel state
  rd_state_e   rstate_q, rstate_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [29:0] raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // write channel state
  wr_state_e   wstate_q, wstate_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [29:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  // write decode and bypass view
  logic        aw_fire, w_fire, have_aw, have_w, wr_commit;
  logic [29:0] wr_word, wr_off;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_hit;
  logic [2:0]  wr_idx;
  logic        we_mtime_lo, we_mtime_hi, we_cmp_lo, we_cmp_hi, we_ctrl;
  logic [63:0] mtime_wv, mtimecmp_wv;
  logic        ctrl_wv;

  // read decode
  logic [29:0] r_off;
  logic        r_hit;
  logic [2:0]  r_idx;
  logic        r_sample;
  logic [31:0] rd_mux;

  // byte offset bits of the addresses carry no meaning in a word-only window
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign arready   = (rstate_q == R_IDLE);
  assign rvalid    = (rstate_q == R_RESP);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign awready   = (wstate_q == W_IDLE) && !aw_held_q;
  assign wready    = (wstate_q == W_IDLE) && !w_held_q;
  assign bvalid    = (wstate_q == W_RESP);
  assign bresp     = bresp_q;
  assign timer_irq = irq_q;

  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;
  assign have_aw   = aw_held_q || aw_fire;
  assign have_w    = w_held_q || w_fire;
  assign wr_commit = (wstate_q == W_IDLE) && have_aw && have_w;
  assign wr_word   = aw_held_q ? awaddr_q : awaddr[31:2];
  assign wr_data   = w_held_q ? wdata_q : wdata;
  assign wr_strb   = w_held_q ? wstrb_q : wstrb;
  assign wr_off    = wr_word - BASE_W;
  assign wr_hit    = (wr_off < 30'd8);
  assign wr_idx    = wr_off[2:0];

  assign we_mtime_lo = wr_commit && wr_hit && (wr_idx == IDX_MTIME_LO);
  assign we_mtime_hi = wr_commit && wr_hit && (wr_idx == IDX_MTIME_HI);
  assign we_cmp_lo   = wr_commit && wr_hit && (wr_idx == IDX_CMP_LO);
  assign we_cmp_hi   = wr_commit && wr_hit && (wr_idx == IDX_CMP_HI);
  assign we_ctrl     = wr_commit && wr_hit && (wr_idx == IDX_CTRL);

  assign r_off    = raddr_q - BASE_W;
  assign r_hit    = (r_off < 30'd8);
  assign r_idx    = r_off[2:0];
  assign r_sample = (rstate_q == R_WAIT) && (rcnt_q == 4'd0);

  // register values with this cycle's committing write already merged in (no increment)
  always_comb begin
    mtime_wv    = mtime_q;
    mtimecmp_wv = mtimecmp_q;
    ctrl_wv     = ctrl_en_q;
    if (we_mtime_lo) mtime_wv[31:0]     = merge_bytes(mtime_q[31:0], wr_data, wr_strb);
    if (we_mtime_hi) mtime_wv[63:32]    = merge_bytes(mtime_q[63:32], wr_data, wr_strb);
    if (we_cmp_lo)   mtimecmp_wv[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
    if (we_cmp_hi)   mtimecmp_wv[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
    if (we_ctrl && wr_strb[0]) ctrl_wv = wr_data[0];
  end

  // prescaler, mtime increment, and bus writes (a write to either mtime half cancels that cycle's tick)
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (ctrl_en_q) begin
      if (presc_q == DIV_MAX) begin
        presc_d = 16'd0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
    if (we_mtime_lo || we_mtime_hi) mtime_d = mtime_wv;
    mtimecmp_d = mtimecmp_wv;
    ctrl_en_d  = ctrl_wv;
    irq_d      = (mtime_q >= mtimecmp_q);
  end

  // read data mux and hi-shadow capture on an mtime_lo sample
  always_comb begin
    rd_mux   = 32'd0;
    shadow_d = shadow_q;
    if (r_hit) begin
      case (r_idx)
        IDX_MTIME_LO: rd_mux = mtime_wv[31:0];
        IDX_MTIME_HI: rd_mux = shadow_q;
        IDX_CMP_LO:   rd_mux = mtimecmp_wv[31:0];
        IDX_CMP_HI:   rd_mux = mtimecmp_wv[63:32];
        IDX_CTRL:     rd_mux = {31'd0, ctrl_wv};
        default:      rd_mux = 32'd0;
      endcase
    end
    if (r_sample && r_hit && (r_idx == IDX_MTIME_LO)) shadow_d = mtime_wv[63:32];
  end

  // read channel next state: accept address, count down latency, hold response until taken
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid) begin
          raddr_d  = araddr[31:2];
          rcnt_d   = RD_CNT_INIT;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          rdata_d  = rd_mux;
          rresp_d  = r_hit ? RESP_OKAY : RESP_DECERR;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // write channel next state: collect AW and W in any order, commit once both are held
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr[31:2];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (wr_commit) begin
          bresp_d  = wr_hit ? RESP_OKAY : RESP_DECERR;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_en_q  <= 1'b1;
      presc_q    <= 16'd0;
      shadow_q   <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_en_q  <= ctrl_en_d;
      presc_q    <= presc_d;
      shadow_q   <= shadow_d;
      irq_q      <= irq_d;
    end
  end

  // read channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= 4'd0;
      raddr_q  <= 30'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // write channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 30'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_clint_slave.sv
// tb/tb_axi_lite_clint_slave.sv - scoreboard bench for the CLINT timer responder
module tb_axi_lite_clint_slave;

  localparam logic [31:0] BASE   = 32'ha0000048;
  localparam int          RD_LAT = 1;
  localparam int          DIV    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        timer_irq;

  axi_lite_clint_slave #(.BASE(BASE), .RD_LAT(RD_LAT), .DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_commit = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rq[$];
  logic [1:0] bq[$];

  // reference model of the timer window
  logic [63:0] m_base;
  logic [63:0] m_cmp;
  int          m_ec;
  bit          m_run;
  logic        m_ctrl;
  logic [31:0] m_shadow;

  function automatic logic [63:0] mt_after(input int e);
    if (m_run) return m_base + 64'(e - m_ec);
    return m_base;
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset(input int e);
    m_base = 64'd0; m_ec = e; m_run = 1'b1;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ctrl = 1'b1; m_shadow = 32'd0;
  endtask

  task automatic model_read(input logic [31:0] a, input int es, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] off;
    logic [63:0] mt;
    off = a - BASE;
    d = 32'd0;
    r = 2'b00;
    if (off >= 32'h20) begin
      r = 2'b11;
    end else begin
      mt = mt_after(es - 1);
      case (off[4:2])
        3'd0: begin d = mt[31:0]; m_shadow = mt[63:32]; end
        3'd1: d = m_shadow;
        3'd2: d = m_cmp[31:0];
        3'd3: d = m_cmp[63:32];
        3'd4: d = {31'd0, m_ctrl};
        default: d = 32'd0;
      endcase
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int e);
    logic [31:0] off;
    logic [63:0] mt;
    off = a - BASE;
    if (off < 32'h20) begin
      case (off[4:2])
        3'd0: begin mt = mt_after(e - 1); mt[31:0] = merge32(mt[31:0], d, s); m_base = mt; m_ec = e; end
        3'd1: begin mt = mt_after(e - 1); mt[63:32] = merge32(mt[63:32], d, s); m_base = mt; m_ec = e; end
        3'd2: m_cmp[31:0] = merge32(m_cmp[31:0], d, s);
        3'd3: m_cmp[63:32] = merge32(m_cmp[63:32], d, s);
        3'd4: begin
          m_base = mt_after(e); m_ec = e;
          if (s[0]) m_ctrl = d[0];
          m_run = m_ctrl;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [31:0] a, input string tag);
    rd_exp_t e;
    int n;
    int lat;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin tick(1); n++; end
    if (!arready) chk({tag, "_ar_timeout"}, 64'(arready), 64'd1);
    tick(1);
    arvalid = 1'b0;
    model_read(a, cyc + RD_LAT, e.data, e.resp);
    rq.push_back(e);
    lat = 0;
    while (!rvalid && lat < 40) begin tick(1); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(RD_LAT));
    e = rq.pop_front();
    chk({tag, "_rdata"}, 64'(rdata), 64'(e.data));
    chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
    rready = 1'b1; tick(1); rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 64'(rvalid), 64'd0);
  endtask

  // lead > 0: W that many cycles before AW; lead < 0: AW first; 0: same cycle
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bhold, input string tag);
    int n;
    int ce;
    bq.push_back(((a - BASE) < 32'h20) ? 2'b00 : 2'b11);
    awaddr = a; wdata = d; wstrb = s;
    if (lead > 0) begin
      wvalid = 1'b1; tick(1); wvalid = 1'b0;
      chk({tag, "_wready_drop"}, 64'(wready), 64'd0);
      tick(lead - 1);
      chk({tag, "_awready_pre"}, 64'(awready), 64'd1);
      awvalid = 1'b1; tick(1); awvalid = 1'b0;
    end else if (lead < 0) begin
      awvalid = 1'b1; tick(1); awvalid = 1'b0;
      chk({tag, "_awready_drop"}, 64'(awready), 64'd0);
      tick(-lead - 1);
      wvalid = 1'b1; tick(1); wvalid = 1'b0;
    end else begin
      awvalid = 1'b1; wvalid = 1'b1; tick(1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    ce = cyc;
    n = 0;
    while (!bvalid && n < 40) begin tick(1); n++; end
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    last_commit = ce;
    model_write(a, d, s, ce);
    for (int i = 0; i < bhold; i++) begin
      tick(1);
      chk({tag, "_bhold_valid"}, 64'(bvalid), 64'd1);
      chk({tag, "_bhold_resp"}, 64'(bresp), 64'(bq[0]));
      chk({tag, "_bhold_awready"}, 64'(awready), 64'd0);
    end
    chk({tag, "_bresp"}, 64'(bresp), 64'(bq.pop_front()));
    bready = 1'b1; tick(1); bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 64'(bvalid), 64'd0);
    chk({tag, "_awready_back"}, 64'(awready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ce;
    tick(3);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd1);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_irq", 64'(timer_irq), 64'd0);
    rst = 1'b0;
    model_reset(cyc);

    do_read(BASE + 32'h10, "ctrl_rst");
    chk("irq_after_rst", 64'(timer_irq), 64'd0);
    do_read(BASE, "mtlo_run");

    do_write(BASE + 32'h10, 32'd0, 4'hF, 0, 0, "ctrl_off");
    do_write(BASE, 32'd0, 4'hF, 0, 0, "mtlo_clr");
    do_write(BASE + 32'h4, 32'd0, 4'hF, 1, 0, "mthi_clr");
    do_write(BASE + 32'hC, 32'd0, 4'hF, 0, 0, "cmphi");
    do_write(BASE + 32'h8, 32'd20, 4'hF, -2, 0, "cmplo");
    chk("irq_before_en", 64'(timer_irq), 64'd0);
    do_write(BASE + 32'h10, 32'd1, 4'hF, 0, 0, "ctrl_on");
    ce = last_commit;
    n = 0;
    while (!timer_irq && n < 100) begin tick(1); n++; end
    chk("irq_rise_cycle", 64'(cyc - ce), 64'd21);
    do_write(BASE + 32'h10, 32'd0, 4'hF, 0, 0, "ctrl_freeze");
    do_read(BASE, "frz_lo1");
    tick(7);
    do_read(BASE, "frz_lo2");
    do_read(BASE + 32'h4, "frz_hi");
    chk("irq_held", 64'(timer_irq), 64'd1);

    do_write(BASE + 32'h4, 32'd0, 4'hF, 0, 0, "wrap_hi_wr");
    do_write(BASE, 32'hFFFF_FFFE, 4'hF, 0, 0, "wrap_lo_wr");
    do_write(BASE + 32'h10, 32'd1, 4'hF, 0, 0, "wrap_run");
    tick(5);
    do_read(BASE, "wrap_lo");
    tick(10);
    do_read(BASE + 32'h4, "wrap_hi");
    do_write(BASE, 32'h0000_0010, 4'hF, 0, 0, "run_lo_wr");
    do_read(BASE, "run_lo_rd");
    do_read(BASE + 32'h4, "run_hi_rd");

    do_write(BASE + 32'h8, 32'h0000_AB00, 4'b0010, 3, 5, "cmp_b1");
    do_read(BASE + 32'h8, "cmp_b1_rd");

    do_read(BASE + 32'h40, "oor_rd");
    do_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, "oor_wr");
    do_read(BASE + 32'h8, "cmp_keep");
    do_read(BASE + 32'h14, "rsv_rd");
    do_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, "rsv_wr");
    do_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'h0, 0, 0, "strb0");
    do_read(BASE + 32'hC, "cmphi_keep");
    do_read(BASE + 32'h10, "ctrl_rd");

    araddr = BASE; arvalid = 1'b1; tick(1); arvalid = 1'b0;
    rst = 1'b1; #1;
    chk("abort_r_rvalid", 64'(rvalid), 64'd0);
    tick(1);
    rst = 1'b0;
    model_reset(cyc);
    chk("abort_r_arready", 64'(arready), 64'd1);
    tick(3);
    chk("abort_r_no_resp", 64'(rvalid), 64'd0);

    awaddr = BASE + 32'h8; wdata = 32'd5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("abort_w_in_resp", 64'(bvalid), 64'd1);
    rst = 1'b1; #1;
    chk("abort_w_bvalid", 64'(bvalid), 64'd0);
    tick(1);
    rst = 1'b0;
    model_reset(cyc);
    chk("abort_w_awready", 64'(awready), 64'd1);
    chk("abort_w_wready", 64'(wready), 64'd1);
    chk("abort_w_arready", 64'(arready), 64'd1);
    tick(3);
    chk("abort_w_no_resp", 64'(bvalid), 64'd0);
    do_read(BASE, "post_rst_lo");
    do_read(BASE + 32'h8, "post_rst_cmplo");
    chk("post_rst_irq", 64'(timer_irq), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
